// File: rtl/sa_job_seq_if.sv
// Sequencer bus bundle: job control, shared word-memory port and array address-mapped port.
// Pure wiring, no latency. Control is strobe-based; no backpressure on either port.
interface sa_job_seq_if #(
    parameter int MEM_AW = 16
);
    logic              go_i;
    logic [MEM_AW-1:0] w_base_i;
    logic [MEM_AW-1:0] x_base_i;
    logic [MEM_AW-1:0] y_base_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_wr_o;
    logic [31:0]       mem_wdata_o;
    logic [7:0]        sa_addr_o;
    logic [31:0]       sa_data_o;
    logic              sa_wr_o;
    logic [31:0]       sa_data_i;

    modport master (
        input  go_i, w_base_i, x_base_i, y_base_i, mem_rdata_i, sa_data_i,
        output busy_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
               sa_addr_o, sa_data_o, sa_wr_o
    );

    modport slave (
        output go_i, w_base_i, x_base_i, y_base_i, mem_rdata_i, sa_data_i,
        input  busy_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
               sa_addr_o, sa_data_o, sa_wr_o
    );
endinterface

// File: rtl/sa_job_seq.sv
// Job sequencer: loads weights/activations into the 8x8 array, starts it, polls done, writes results back.
// Latency: 264 cycles go->done with immediate done (328 with SA_SEQ_CLEAR_OBUF_EN clearing output buffers).
// Backpressure: none; memory answers in exactly 1 cycle, array read data is registered, go_i dropped when busy.
module sa_job_seq #(
    parameter int MEM_AW   = 16,
    parameter int POLL_MAX = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sa_job_seq_if.master bus
);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDW   = 3'd1,
        S_LDX   = 3'd2,
`ifdef SA_SEQ_CLEAR_OBUF_EN
        S_CLR   = 3'd3,
`endif
        S_START = 3'd4,
        S_POLL  = 3'd5,
        S_RD    = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [PW-1:0]     pcnt;
    logic [MEM_AW-1:0] w_base, x_base, y_base;
    logic              err;
    logic [31:0]       cap;

    logic              poll_sample, poll_miss, poll_timeout;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_wdata;
    logic [7:0]        sa_addr;
    logic [31:0]       sa_data;
    logic              sa_wr;

    // POLL cycle 0 only presents address 0x00; the array's registered status is valid from cycle 1.
    assign poll_sample  = (state == S_POLL) && (cnt != 8'd0);
    assign poll_miss    = poll_sample && !bus.sa_data_i[0];
    assign poll_timeout = poll_miss && (pcnt == PW'(POLL_MAX - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            w_base <= '0;
            x_base <= '0;
            y_base <= '0;
            err    <= 1'b0;
            cap    <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state != S_IDLE && !poll_sample)
                cnt <= cnt + 8'd1;
            if (state == S_IDLE && bus.go_i) begin
                w_base <= bus.w_base_i;
                x_base <= bus.x_base_i;
                y_base <= bus.y_base_i;
                err    <= 1'b0;
            end
            if (state == S_START)
                pcnt <= '0;
            else if (poll_miss)
                pcnt <= pcnt + 1'b1;
            if (poll_timeout)
                err <= 1'b1;
            if (state == S_RD && cnt[0])
                cap <= bus.sa_data_i;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        sa_addr   = '0;
        sa_data   = '0;
        sa_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.go_i)
                    state_nxt = S_LDW;
            end
            S_LDW: begin
                // Read of word n overlaps the array write of word n-1.
                if (cnt != 8'd64) begin
                    mem_rd   = 1'b1;
                    mem_addr = w_base + MEM_AW'(cnt);
                end
                if (cnt != 8'd0) begin
                    sa_wr   = 1'b1;
                    sa_addr = cnt - 8'd1;
                    sa_data = bus.mem_rdata_i;
                end
                if (cnt == 8'd64)
                    state_nxt = S_LDX;
            end
            S_LDX: begin
                if (cnt != 8'd64) begin
                    mem_rd   = 1'b1;
                    mem_addr = x_base + MEM_AW'(cnt);
                end
                if (cnt != 8'd0) begin
                    sa_wr   = 1'b1;
                    sa_addr = 8'h40 | (cnt - 8'd1);
                    sa_data = bus.mem_rdata_i;
                end
                if (cnt == 8'd64) begin
`ifdef SA_SEQ_CLEAR_OBUF_EN
                    state_nxt = S_CLR;
`else
                    state_nxt = S_START;
`endif
                end
            end
`ifdef SA_SEQ_CLEAR_OBUF_EN
            S_CLR: begin
                sa_wr   = 1'b1;
                sa_addr = 8'h80 | cnt;
                if (cnt == 8'd63)
                    state_nxt = S_START;
            end
`endif
            S_START: begin
                sa_wr     = 1'b1;
                sa_addr   = 8'hC0;
                state_nxt = S_POLL;
            end
            S_POLL: begin
                if (poll_sample) begin
                    if (bus.sa_data_i[0])
                        state_nxt = S_RD;
                    else if (poll_timeout)
                        state_nxt = S_DONE;
                end
            end
            S_RD: begin
                // Word n: address held on cycles 2n and 2n+1, captured on 2n+1, written to memory on 2n+2.
                if (!cnt[7])
                    sa_addr = 8'h80 | {2'b00, cnt[6:1]};
                if (cnt[7:1] != 7'd0 && !cnt[0]) begin
                    mem_wr    = 1'b1;
                    mem_addr  = y_base + MEM_AW'(cnt[7:1] - 7'd1);
                    mem_wdata = cap;
                end
                if (cnt == 8'd128)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy_o      = (state != S_IDLE) && (state != S_DONE);
    assign bus.done_o      = (state == S_DONE);
    assign bus.err_o       = err;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_rd_o    = mem_rd;
    assign bus.mem_wr_o    = mem_wr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.sa_addr_o   = sa_addr;
    assign bus.sa_data_o   = sa_data;
    assign bus.sa_wr_o     = sa_wr;
endmodule

// File: tb/tb_sa_job_seq.sv
// Directed bench for sa_job_seq: memory model with address checking, array stub, timeout instance.
module tb_sa_job_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef SA_SEQ_CLEAR_OBUF_EN
    localparam int CLR_CYC = 64;
    localparam bit CLEAR   = 1'b1;
`else
    localparam int CLR_CYC = 0;
    localparam bit CLEAR   = 1'b0;
`endif

    sa_job_seq_if #(.MEM_AW(16)) bus ();
    sa_job_seq_if #(.MEM_AW(16)) bus_to ();

    sa_job_seq #(.MEM_AW(16), .POLL_MAX(255)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.master)
    );
    sa_job_seq #(.MEM_AW(16), .POLL_MAX(10)) dut_to (
        .clk_i(clk), .rst_i(rst), .bus(bus_to.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- memory model (main instance) ----------------
    logic [31:0] ymem [0:65535];
    logic [31:0] mem_rdata = 32'h0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, bad_addr = 0, done_cnt = 0;
    int rd_mark = 0, wr_mark = 0;

    function automatic logic [31:0] src_word(input logic [15:0] a, input logic [15:0] wb,
                                             input logic [15:0] xb);
        logic [15:0] iw, ix;
        iw = a - wb;
        ix = a - xb;
        if (iw < 16'd64) return (iw[5:3] == iw[2:0]) ? 32'd1 : 32'd0;
        if (ix < 16'd64) return {16'h0, ix} + 32'd1;
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [15:0] exp_rd_addr(input int idx, input logic [15:0] wb,
                                                input logic [15:0] xb);
        if (idx < 64) return wb + 16'(idx);
        return xb + 16'(idx - 64);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_o) begin
            mem_rdata <= src_word(bus.mem_addr_o, bus.w_base_i, bus.x_base_i);
            rd_cnt    <= rd_cnt + 1;
            if (bus.mem_addr_o !== exp_rd_addr(rd_cnt - rd_mark, bus.w_base_i, bus.x_base_i))
                bad_addr <= bad_addr + 1;
        end
        if (bus.mem_wr_o) begin
            ymem[bus.mem_addr_o] <= bus.mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
            if (bus.mem_addr_o !== 16'(bus.y_base_i + 16'(wr_cnt - wr_mark)))
                bad_addr <= bad_addr + 1;
        end
        if (bus.mem_rd_o && bus.mem_wr_o) both_cnt <= both_cnt + 1;
        if (bus.done_o) done_cnt <= done_cnt + 1;
    end
    assign bus.mem_rdata_i = mem_rdata;

    // ---------------- array stub: Y[c][e] += sum_k W[k*8+c]*X[e*8+k] ----------------
    logic [31:0] aw [0:63];
    logic [31:0] ax [0:63];
    logic [31:0] obuf [0:63];
    logic [31:0] sa_rd = 32'h0;
    logic        running = 1'b0;
    logic        inited = 1'b0;
    int          t = 0;
    int          dly = 0;

    function automatic logic [31:0] mac(input int c, input int e);
        logic [31:0] s;
        s = 32'h0;
        for (int k = 0; k < 8; k++) s = s + aw[k*8+c] * ax[e*8+k];
        return s;
    endfunction

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 64; i++) obuf[i] <= 32'h0;
            inited <= 1'b1;
        end else if (bus.sa_wr_o) begin
            case (bus.sa_addr_o[7:6])
                2'b00: aw[bus.sa_addr_o[5:0]] <= bus.sa_data_o;
                2'b01: ax[bus.sa_addr_o[5:0]] <= bus.sa_data_o;
                2'b10: obuf[bus.sa_addr_o[5:0]] <= bus.sa_data_o;
                default: begin
                    running <= 1'b1;
                    t <= 0;
                    for (int c = 0; c < 8; c++)
                        for (int e = 0; e < 8; e++)
                            obuf[c*8+e] <= obuf[c*8+e] + mac(c, e);
                end
            endcase
        end else if (running) begin
            t <= t + 1;
        end
        if (bus.sa_addr_o == 8'h00)
            sa_rd <= {31'h0, running && (t >= dly)};
        else if (bus.sa_addr_o[7:6] == 2'b10)
            sa_rd <= obuf[bus.sa_addr_o[5:0]];
        else
            sa_rd <= 32'h0;
    end
    assign bus.sa_data_i = sa_rd;

    // ---------------- timeout instance: array never reports done ----------------
    int to_rd = 0, to_wr = 0, to_done = 0;
    assign bus_to.mem_rdata_i = 32'h0;
    assign bus_to.sa_data_i   = 32'h0;
    always @(posedge clk) begin
        if (bus_to.mem_rd_o) to_rd <= to_rd + 1;
        if (bus_to.mem_wr_o) to_wr <= to_wr + 1;
        if (bus_to.done_o)   to_done <= to_done + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  64'(bus.busy_o),      64'd0);
        chk({tag, "_done"},  64'(bus.done_o),      64'd0);
        chk({tag, "_err"},   64'(bus.err_o),       64'd0);
        chk({tag, "_maddr"}, 64'(bus.mem_addr_o),  64'd0);
        chk({tag, "_mrd"},   64'(bus.mem_rd_o),    64'd0);
        chk({tag, "_mwr"},   64'(bus.mem_wr_o),    64'd0);
        chk({tag, "_mwdat"}, 64'(bus.mem_wdata_o), 64'd0);
        chk({tag, "_saddr"}, 64'(bus.sa_addr_o),   64'd0);
        chk({tag, "_sdat"},  64'(bus.sa_data_o),   64'd0);
        chk({tag, "_swr"},   64'(bus.sa_wr_o),     64'd0);
    endtask

    // x = 1..64 through identity weights: result word n (column n/8, entry n%8) is x[(n%8)*8 + n/8].
    function automatic logic [31:0] exp_y(input int n, input int mult);
        return 32'(((n % 8) * 8 + n / 8 + 1) * mult);
    endfunction

    task automatic check_y(input string tag, input logic [15:0] y, input int mult);
        for (int n = 0; n < 64; n++)
            chk($sformatf("%s_y%0d", tag, n), 64'(ymem[16'(y + 16'(n))]), 64'(exp_y(n, mult)));
    endtask

    // Go is driven in cycle 0; cyc is the index of the cycle in which done_o is seen.
    task automatic run_main(input logic [15:0] w, input logic [15:0] x, input logic [15:0] y,
                            input int glitch, output int cyc, output bit ok);
        rd_mark = rd_cnt;
        wr_mark = wr_cnt;
        bus.w_base_i = w;
        bus.x_base_i = x;
        bus.y_base_i = y;
        bus.go_i = 1'b1;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 2000 && !ok) begin
            @(negedge clk);
            cyc++;
            bus.go_i = (cyc == glitch);
            if (bus.done_o) ok = 1'b1;
        end
    endtask

    task automatic wait_to(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 2000 && !ok) begin
            @(negedge clk);
            cyc++;
            bus_to.go_i = 1'b0;
            if (bus_to.done_o) ok = 1'b1;
        end
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  dmark;
        int  rmark;
        int  wmark;
        bit  found;

        bus.go_i = 1'b0;
        bus.w_base_i = '0;
        bus.x_base_i = '0;
        bus.y_base_i = '0;
        bus_to.go_i = 1'b0;
        bus_to.w_base_i = 16'h0100;
        bus_to.x_base_i = 16'h0200;
        bus_to.y_base_i = 16'h0300;

        @(negedge clk);
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Job A: done 24 cycles after START, extra go mid-LDX, go in DONE cycle
        dly = 24;
        dmark = done_cnt;
        run_main(16'h0100, 16'h0200, 16'h0300, 100, cyc, ok);
        chk("A_done_seen", 64'(ok), 64'd1);
        chk("A_err", 64'(bus.err_o), 64'd0);
        bus.go_i = 1'b1;
        @(negedge clk);
        bus.go_i = 1'b0;
        chk("A_go_in_done_dropped", 64'(bus.busy_o), 64'd0);
        chk("A_done_once", 64'(done_cnt - dmark), 64'd1);
        chk("A_reads", 64'(rd_cnt - rd_mark), 64'd128);
        chk("A_writes", 64'(wr_cnt - wr_mark), 64'd64);
        chk("A_addr_seq", 64'(bad_addr), 64'd0);
        chk("A_rd_wr_overlap", 64'(both_cnt), 64'd0);
        check_y("A", 16'h0300, 1);

        // Job B: immediate done; results wrap past 0xFFFF
        dly = 0;
        @(negedge clk);
        run_main(16'h0100, 16'h0200, 16'hFFE0, -1, cyc, ok);
        chk("B_done_seen", 64'(ok), 64'd1);
        chk("B_latency", 64'(cyc), 64'(263 + CLR_CYC));
        chk("B_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        chk("B_writes", 64'(wr_cnt - wr_mark), 64'd64);
        chk("B_addr_seq", 64'(bad_addr), 64'd0);
        check_y("B", 16'hFFE0, CLEAR ? 1 : 2);

        // Timeout instance: 10 polls then done with err
        bus_to.go_i = 1'b1;
        wait_to(cyc, ok);
        chk("T_done_seen", 64'(ok), 64'd1);
        chk("T_latency", 64'(cyc), 64'(143 + CLR_CYC));
        chk("T_err", 64'(bus_to.err_o), 64'd1);
        chk("T_reads", 64'(to_rd), 64'd128);
        chk("T_no_writes", 64'(to_wr), 64'd0);
        @(negedge clk);
        chk("T_err_held", 64'(bus_to.err_o), 64'd1);
        chk("T_done_once", 64'(to_done), 64'd1);
        bus_to.go_i = 1'b1;
        @(negedge clk);
        bus_to.go_i = 1'b0;
        chk("T2_err_cleared", 64'(bus_to.err_o), 64'd0);
        chk("T2_busy", 64'(bus_to.busy_o), 64'd1);
        wait_to(cyc, ok);
        chk("T2_err", 64'(bus_to.err_o), 64'd1);
        chk("T2_no_writes", 64'(to_wr), 64'd0);

        // Job D: reset at RD word 20
        dly = 24;
        @(negedge clk);
        dmark = done_cnt;
        rd_mark = rd_cnt;
        wr_mark = wr_cnt;
        bus.w_base_i = 16'h1000;
        bus.x_base_i = 16'h1100;
        bus.y_base_i = 16'h1200;
        bus.go_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            bus.go_i = 1'b0;
            if (bus.sa_addr_o == 8'h94 && !bus.sa_wr_o && bus.busy_o) found = 1'b1;
        end
        chk("D_reached_rd20", 64'(found), 64'd1);
        rmark = rd_cnt;
        wmark = wr_cnt;
        #2 rst = 1'b1;
        #1 chk_idle("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("D_no_done", 64'(done_cnt - dmark), 64'd0);
        chk("D_idle_rd", 64'(rd_cnt - rmark), 64'd0);
        chk("D_idle_wr", 64'(wr_cnt - wmark), 64'd0);
        chk("D_busy", 64'(bus.busy_o), 64'd0);

        // Job E: clean run after reset; obuf has accumulated A, B and D without clearing
        dly = 5;
        dmark = done_cnt;
        run_main(16'h2000, 16'h2100, 16'h0500, -1, cyc, ok);
        chk("E_done_seen", 64'(ok), 64'd1);
        chk("E_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        chk("E_done_once", 64'(done_cnt - dmark), 64'd1);
        chk("E_reads", 64'(rd_cnt - rd_mark), 64'd128);
        chk("E_writes", 64'(wr_cnt - wr_mark), 64'd64);
        chk("E_addr_seq", 64'(bad_addr), 64'd0);
        chk("E_rd_wr_overlap", 64'(both_cnt), 64'd0);
        check_y("E", 16'h0500, CLEAR ? 1 : 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_job_seq.md
# sa_job_seq

Job sequencer for the 8x8 systolic array top. From a single `go_i` pulse it copies 64 weights and 64 activations from a shared word memory into the array's address-mapped write port, optionally clears the output buffers, starts the array, and polls the status bit until done. It then reads all 64 accumulator words back and writes them to memory. It replaces host-driven poking of the array's `addr_i`/`data_i`/`wr_vi` bus and sits between the memory fabric and the array top.

## Interface
Parameters:
- `MEM_AW`, 16: memory word-address width.
- `POLL_MAX`, 255: maximum poll reads before declaring timeout; width of the poll counter is `$clog2(POLL_MAX+1)`.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `go_i` in 1: one-cycle job request; ignored unless idle.
- `w_base_i`, `x_base_i`, `y_base_i` in `MEM_AW` each: weight, activation and result base word addresses; sampled when `go_i` is accepted.
- `busy_o` out 1: high from the cycle after acceptance until `done_o`.
- `done_o` out 1: one-cycle pulse at job end.
- `err_o` out 1: timeout flag, valid with `done_o`, held until next accepted `go_i`.
- `mem_addr_o` out `MEM_AW`: memory address.
- `mem_rd_o` out 1: memory read strobe; `mem_rdata_i` is valid exactly 1 cycle later.
- `mem_rdata_i` in 32: memory read data.
- `mem_wr_o` out 1: memory write strobe.
- `mem_wdata_o` out 32: memory write data.
- `sa_addr_o` out 8: array address.
- `sa_data_o` out 32: array write data.
- `sa_wr_o` out 1: array write strobe.
- `sa_data_i` in 32: array read data, registered by the array (1-cycle latency).

## Operation
States: IDLE -> LDW -> LDX -> [CLR] -> START -> POLL -> RD -> DONE -> IDLE.
- IDLE: `go_i`=1 latches the three base addresses, clears `err_o`, and moves to LDW.
- LDW: word counter n runs 0..63. Each cycle n issues `mem_rd_o` at `w_base+n`; cycle n+1 drives `sa_wr_o`=1, `sa_addr_o`=n, `sa_data_o`=`mem_rdata_i`. Reads and writes are pipelined, so 65 cycles in total. The state exits after the array write of n=63.
- LDX: same pipelining, memory `x_base+n` to array address 0x40+n, 65 cycles.
- CLR (only with the macro): 64 cycles writing `sa_data_o`=0 to 0x80+n.
- START: one cycle with `sa_wr_o`=1 and `sa_addr_o`=0xC0, `sa_data_o`=0.
- POLL: drives `sa_addr_o`=0x00 with `sa_wr_o`=0 and samples `sa_data_i[0]` every cycle. The first sample is taken 2 cycles after START, so the status bit has already dropped.
  - Bit=1: go to RD.
  - Otherwise the poll counter increments. When it reaches `POLL_MAX`, set `err_o`=1 and go to DONE with no writeback.
- RD: for n 0..63, hold `sa_addr_o`=0x80+n for 2 cycles and capture `sa_data_i` on the second. n[5:3] selects the column and n[2:0] the entry. On the next cycle, pulse `mem_wr_o` at `y_base+n` with the captured word; this overlaps the first cycle of word n+1. The state lasts 129 cycles.
- DONE: `done_o`=1 for one cycle, `busy_o` goes low the same cycle, then IDLE.
- Address arithmetic is `base+n` modulo 2^`MEM_AW`; wrap-around is permitted and not flagged.
- `mem_rd_o` and `mem_wr_o` are never high in the same cycle. `sa_wr_o` is never high in POLL or RD.

## Timing
- Reset values: every output is 0 and the state is IDLE; reset takes effect immediately and mid-job with no completion pulse.
- `go_i` is accepted in IDLE only; `go_i` while busy, or in the DONE cycle, is dropped.
- Without CLR, a job with immediate done takes 1+65+65+1+2+129+1 = 264 cycles from `go_i` to `done_o`; with CLR it takes 328.
- `done_o` is asserted in the cycle after the last `mem_wr_o` (the cycle after the last poll on timeout).

## Configuration
- `SA_SEQ_CLEAR_OBUF_EN` defined: the CLR state is compiled in, and every job starts from zeroed output buffers.
- Not defined: the CLR state is absent, LDX goes directly to START, and results accumulate onto the prior buffer contents.

## Test plan
- Memory holds weight = identity and x = 1..64, with done asserted 24 cycles after START. Required response: the 64 results appear at `y_base`, `done_o` fires once, and `err_o`=0.
- A memory model checks strobes and addresses. Required: exactly 64 reads at `w_base`, then 64 at `x_base`, exactly 64 writes at `y_base`, and never `mem_rd_o`&`mem_wr_o` together.
- A stub array never asserts done, with `POLL_MAX`=10. Required: `done_o` fires after 10 polls with `err_o`=1 and no `mem_wr_o`.
- `go_i` is pulsed again mid-LDX. Required: it is ignored and the job completes normally. `go_i` in IDLE after `done_o` starts a new job and clears `err_o`.
- `rst_i` is asserted during RD at n=20. Required: all outputs are 0 in the same cycle, the state is IDLE, and a subsequent job runs clean.
- Two jobs run back-to-back with the macro defined give identical results. Without the macro, the second job's results equal twice the first.
